sal_axi_req_arbiter: RTL

Merges the AXI AW and AR address channels into one request stream for the DDR2 controller's request queue. Each channel has a one-entry holding register. A read-priority FSM with bounded streaks picks a winner. The winner goes into a registered output slot tagged with a write flag. The block sits between the interconnect-facing address channels and the scheduler, and stalls writes when the write-data buffer has no room for a burst.

---
 rtl/sal_ddr2_pkg.sv | 34 +++
 rtl/sal_axi_hold_reg.sv | 33 +++
 rtl/sal_axi_req_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sal_ddr2_pkg.sv
// Shared DDR2 front-end types: unified request struct and arbiter FSM states.
// Width defaults come from AXI_ADDR_WIDTH / AXI_ID_WIDTH when not set by the build.
`ifndef AXI_ADDR_WIDTH
  `define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
  `define AXI_ID_WIDTH 4
`endif

package sal_ddr2_pkg;

  localparam int AXI_ADDR_W = `AXI_ADDR_WIDTH;
  localparam int AXI_ID_W   = `AXI_ID_WIDTH;
  localparam int AXI_LEN_W  = 4;

  typedef struct packed {
    logic                  write;
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_LEN_W-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } req_t;

  typedef enum logic {
    RD_PRIO = 1'b0,
    WR_PRIO = 1'b1
  } arb_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sal_axi_hold_reg.sv
// One-entry holding register for an AXI address channel; a grant frees the
// entry and a same-cycle handshake refills it.
module sal_axi_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         grant,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
    end else if (grant) begin
      out_valid <= 1'b0;
    end
  end

  // Payload only matters while out_valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) out_data <= in_data;
  end

endmodule

// File: rtl/sal_axi_req_arbiter.sv
// Merges AXI AW/AR into one tagged request stream with a read-priority,
// bounded-streak arbiter. Optional grant counters under SAL_ARB_STATS_EN.
module sal_axi_req_arbiter
  import sal_ddr2_pkg::*;
#(
  parameter int ADDR_WIDTH    = AXI_ADDR_W,
  parameter int ID_WIDTH      = AXI_ID_W,
  parameter int LEN_WIDTH     = AXI_LEN_W,
  parameter int RD_MAX_STREAK = 4,
  parameter int WR_BATCH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SAL_ARB_STATS_EN
  output logic [31:0]           stat_rd_grants,
  output logic [31:0]           stat_wr_grants,
`endif
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic [LEN_WIDTH-1:0]  aw_len,
  input  logic [2:0]            aw_size,
  input  logic [1:0]            aw_burst,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [LEN_WIDTH-1:0]  ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  input  logic                  wbuf_ready,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ID_WIDTH-1:0]   req_id,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [LEN_WIDTH-1:0]  req_len,
  output logic [2:0]            req_size,
  output logic [1:0]            req_burst
);

  localparam int PW = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 5;
  localparam int SW = $clog2(max2(RD_MAX_STREAK, WR_BATCH) + 1);
  localparam logic [SW-1:0] RD_LIM = SW'(RD_MAX_STREAK);
  localparam logic [SW-1:0] WR_LIM = SW'(WR_BATCH);

  logic          hw_valid, hr_valid;
  logic [PW-1:0] hw_data, hr_data;
  logic          grant_w, grant_r;
  logic          wr_cand, rd_cand, slot_free;
  arb_state_t    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  req_t          slot_q;

  sal_axi_hold_reg #(.W(PW)) u_aw_hold (
    .clk(clk), .rst_n(rst_n), .in_valid(aw_valid), .in_ready(aw_ready),
    .in_data({aw_id, aw_addr, aw_len, aw_size, aw_burst}),
    .grant(grant_w), .out_valid(hw_valid), .out_data(hw_data)
  );

  sal_axi_hold_reg #(.W(PW)) u_ar_hold (
    .clk(clk), .rst_n(rst_n), .in_valid(ar_valid), .in_ready(ar_ready),
    .in_data({ar_id, ar_addr, ar_len, ar_size, ar_burst}),
    .grant(grant_r), .out_valid(hr_valid), .out_data(hr_data)
  );

  assign wr_cand   = hw_valid && wbuf_ready;
  assign rd_cand   = hr_valid;
  assign slot_free = !req_valid || req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RD_PRIO;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // A grant made in the cycle of a state change counts toward the new state's
  // streak, which is what yields the R,R,R,R,W,W cadence under saturation.
  always_comb begin
    grant_w  = 1'b0;
    grant_r  = 1'b0;
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      RD_PRIO: begin
        if (wr_cand && (!rd_cand || streak_q >= RD_LIM)) begin
          grant_w = slot_free;
          if (slot_free && streak_q >= RD_LIM) begin
            state_d  = WR_PRIO;
            streak_d = SW'(1);
          end
        end else if (rd_cand) begin
          grant_r = slot_free;
          if (!wr_cand)       streak_d = '0;
          else if (slot_free) streak_d = streak_q + SW'(1);
        end else begin
          streak_d = '0;
        end
      end
      WR_PRIO: begin
        if (!wr_cand || streak_q >= WR_LIM) begin
          state_d  = RD_PRIO;
          streak_d = '0;
          if (slot_free && rd_cand) begin
            grant_r = 1'b1;
            if (wr_cand) streak_d = SW'(1);
          end else if (slot_free && wr_cand) begin
            grant_w = 1'b1;
          end
        end else if (slot_free) begin
          grant_w  = 1'b1;
          streak_d = streak_q + SW'(1);
        end
      end
      default: state_d = RD_PRIO;
    endcase
  end

  // Output slot: loads on grant, holds until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid <= 1'b0;
      slot_q    <= '0;
    end else if (grant_w) begin
      req_valid <= 1'b1;
      slot_q    <= req_t'({1'b1, hw_data});
    end else if (grant_r) begin
      req_valid <= 1'b1;
      slot_q    <= req_t'({1'b0, hr_data});
    end else if (req_ready) begin
      req_valid <= 1'b0;
    end
  end

  assign {req_write, req_id, req_addr, req_len, req_size, req_burst} = slot_q;

`ifdef SAL_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_grants <= '0;
      stat_wr_grants <= '0;
    end else begin
      if (grant_r && stat_rd_grants != '1) stat_rd_grants <= stat_rd_grants + 32'd1;
      if (grant_w && stat_wr_grants != '1) stat_wr_grants <= stat_wr_grants + 32'd1;
    end
  end
`endif

endmodule
